// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: multi-channel servo PWM generator.
//
// A prescaler divides clk into ticks; a tick counter walks one frame of PERIOD_TICKS ticks.
// Each channel drives its output high while the frame position is below its active pulse
// width. Pulse widths are double buffered: writes land in a pending register and move to
// the active register at the frame wrap, or continuously while the timebase is disabled.
//
// Build option: define SERVO_PWM_CLAMP_EN to limit written pulse widths to
// [MIN_PULSE, MAX_PULSE]. Without it, widths are stored exactly as written.

module servo_pwm_gen #(
    parameter int unsigned CLK_DIV      = 100,
    parameter int unsigned PERIOD_TICKS = 20000,
    parameter int unsigned CNT_W        = 15,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned MIN_PULSE    = 1000,
    parameter int unsigned MAX_PULSE    = 2000,
    parameter int unsigned RST_PULSE    = 1500
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*CNT_W-1:0] pw_in,
    input  logic [CHANNELS-1:0]       pw_wr,
    output logic [CNT_W-1:0]          tick_cnt,
    output logic                      tick,
    output logic                      frame_start,
    output logic [CHANNELS*CNT_W-1:0] pw_active,
    output logic [CHANNELS-1:0]       pwm_out
);

    localparam int unsigned      PRESC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [CNT_W-1:0] PW_RESET   = CNT_W'(RST_PULSE);

`ifdef SERVO_PWM_CLAMP_EN
    localparam logic [CNT_W-1:0] PW_MIN = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] PW_MAX = CNT_W'(MAX_PULSE);
`endif

    // Reject configurations the counters and clamps cannot represent.
    if (CLK_DIV < 2) begin : gen_bad_clk_div
        $error("servo_pwm_gen: CLK_DIV must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(PERIOD_TICKS)) begin : gen_bad_cnt_w
        $error("servo_pwm_gen: CNT_W too narrow for PERIOD_TICKS");
    end
    if (!(MIN_PULSE <= RST_PULSE && RST_PULSE <= MAX_PULSE && MAX_PULSE < PERIOD_TICKS))
    begin : gen_bad_pulse
        $error("servo_pwm_gen: pulse limits out of order");
    end

    // Limit a written width to the legal servo range when clamping is built in.
    function automatic logic [CNT_W-1:0] limit_pw(input logic [CNT_W-1:0] v);
`ifdef SERVO_PWM_CLAMP_EN
        if (v < PW_MIN) begin
            return PW_MIN;
        end else if (v > PW_MAX) begin
            return PW_MAX;
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    // ------------------------------------------------------------------------------------
    // Timebase state
    // ------------------------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               tick_q, tick_d;
    logic               frame_start_q, frame_start_d;

    logic               presc_wrap;
    logic               frame_wrap;
    logic               shadow_load;

    // ------------------------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------------------------
    logic [CNT_W-1:0]    pw_new    [CHANNELS];
    logic [CNT_W-1:0]    pending_q [CHANNELS];
    logic [CNT_W-1:0]    pending_d [CHANNELS];
    logic [CNT_W-1:0]    active_q  [CHANNELS];
    logic [CNT_W-1:0]    active_d  [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    // Prescaler, tick counter and their one-cycle strobes; everything holds while en=0.
    always_comb begin
        presc_wrap    = en && (presc_q == PRESC_LAST);
        frame_wrap    = presc_wrap && (tick_cnt_q == CNT_LAST);
        presc_d       = presc_q;
        tick_cnt_d    = tick_cnt_q;
        tick_d        = presc_wrap;
        frame_start_d = frame_wrap;

        if (en) begin
            presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        end
        if (presc_wrap) begin
            tick_cnt_d = frame_wrap ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // Pending loads on write; active follows pending at the frame wrap or while disabled.
    // Taking pending_d rather than pending_q gives a write on a load edge immediate effect.
    always_comb begin
        shadow_load = frame_wrap || !en;
        for (int i = 0; i < CHANNELS; i++) begin
            pw_new[i]    = limit_pw(pw_in[i*CNT_W +: CNT_W]);
            pending_d[i] = pw_wr[i] ? pw_new[i] : pending_q[i];
            active_d[i]  = shadow_load ? pending_d[i] : active_q[i];
        end
    end

    // Output compare on current register values, registered for glitch-free pins.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = en && (tick_cnt_q < active_q[i]);
        end
    end

    // Timebase registers; reset abandons the current frame outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q       <= '0;
            tick_cnt_q    <= '0;
            tick_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            tick_cnt_q    <= tick_cnt_d;
            tick_q        <= tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Pulse-width buffers and output pins; widths return to servo neutral on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pending_q[i] <= PW_RESET;
                active_q[i]  <= PW_RESET;
            end
            pwm_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pending_q[i] <= pending_d[i];
                active_q[i]  <= active_d[i];
            end
            pwm_q <= pwm_d;
        end
    end

    // Flatten the active widths onto the status bus.
    always_comb begin
        pw_active = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pw_active[i*CNT_W +: CNT_W] = active_q[i];
        end
    end

    assign tick_cnt    = tick_cnt_q;
    assign tick        = tick_q;
    assign frame_start = frame_start_q;
    assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen with a shrunk timebase:
// 4 clocks per tick, 20 ticks per frame (80 clocks), limits 5..10, neutral 7.

module tb_servo_pwm_gen;

    localparam int unsigned CW = 5;

    logic          clk;
    logic          rst;
    logic          en;
    logic [2*CW-1:0] pw_in;
    logic [1:0]    pw_wr;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          frame_start;
    logic [2*CW-1:0] pw_active;
    logic [1:0]    pwm_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    servo_pwm_gen #(
        .CLK_DIV      (4),
        .PERIOD_TICKS (20),
        .CNT_W        (CW),
        .CHANNELS     (2),
        .MIN_PULSE    (5),
        .MAX_PULSE    (10),
        .RST_PULSE    (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pw_in       (pw_in),
        .pw_wr       (pw_wr),
        .tick_cnt    (tick_cnt),
        .tick        (tick),
        .frame_start (frame_start),
        .pw_active   (pw_active),
        .pwm_out     (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock; outputs are sampled just after the edge, inputs change at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pw(input logic [1:0] mask, input logic [CW-1:0] v0,
                            input logic [CW-1:0] v1);
        pw_in = {v1, v0};
        pw_wr = mask;
        step();
        pw_wr = 2'b00;
    endtask

    // Stop on the first sample where tick_cnt has just stepped to v.
    task automatic wait_tick_cnt(input int unsigned v);
        int unsigned n = 0;
        do begin
            step();
            n++;
        end while (!(tick && (32'(tick_cnt) == v)) && n < 200);
        check_eq("wait_tick_cnt", {31'd0, tick && (32'(tick_cnt) == v)}, 1);
    endtask

    task automatic wait_fs();
        int unsigned n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 200);
        check_eq("wait_frame_start", {31'd0, frame_start}, 1);
    endtask

    // Count high cycles per channel over the 80 clocks that follow a frame_start sample.
    task automatic measure_frame(output int unsigned hi0, output int unsigned hi1);
        hi0 = 0;
        hi1 = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (pwm_out[0]) hi0++;
            if (pwm_out[1]) hi1++;
        end
        check_eq("frame_len", {31'd0, frame_start}, 1);
    endtask

    initial begin
        int          last_tick;
        int          last_fs;
        int unsigned exp_cnt;
        int unsigned n_ticks;
        int unsigned n_fs;
        int unsigned run [2];
        int unsigned falls [2];
        int unsigned hi0;
        int unsigned hi1;
        int unsigned prev_act0;
        int unsigned strobes;
        int unsigned n;

        rst   = 1'b1;
        en    = 1'b0;
        pw_in = '0;
        pw_wr = 2'b00;
        step();
        step();

        // Reset state
        check_eq("rst_tick_cnt", 32'(tick_cnt), 0);
        check_eq("rst_tick", {31'd0, tick}, 0);
        check_eq("rst_frame_start", {31'd0, frame_start}, 0);
        check_eq("rst_pwm", 32'(pwm_out), 0);
        check_eq("rst_active0", 32'(pw_active[4:0]), 7);
        check_eq("rst_active1", 32'(pw_active[9:5]), 7);

        // 1: free-running timebase for 200 clocks
        rst       = 1'b0;
        en        = 1'b1;
        last_tick = -1;
        last_fs   = -1;
        exp_cnt   = 1;
        n_ticks   = 0;
        n_fs      = 0;
        run       = '{0, 0};
        falls     = '{0, 0};
        for (int c = 1; c <= 200; c++) begin
            step();
            if (tick) begin
                if (last_tick >= 0) check_eq("tick_period", 32'(c - last_tick), 4);
                else                check_eq("first_tick", 32'(c), 4);
                check_eq("tick_cnt_seq", 32'(tick_cnt), exp_cnt);
                exp_cnt   = (exp_cnt + 1) % 20;
                last_tick = c;
                n_ticks++;
            end
            if (frame_start) begin
                check_eq("fs_at_zero", 32'(tick_cnt), 0);
                if (last_fs >= 0) check_eq("frame_period", 32'(c - last_fs), 80);
                else              check_eq("first_fs", 32'(c), 80);
                last_fs = c;
                n_fs++;
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (pwm_out[ch]) begin
                    run[ch]++;
                end else if (run[ch] > 0) begin
                    check_eq("pwm_run_neutral", run[ch], 28);
                    falls[ch]++;
                    run[ch] = 0;
                end
            end
        end
        check_eq("tick_count", n_ticks, 50);
        check_eq("fs_count", n_fs, 2);
        check_eq("pulses_ch0", falls[0], 3);
        check_eq("pulses_ch1", falls[1], 3);

        // 2: mid-frame write is held back until the next frame
        wait_tick_cnt(3);
        write_pw(2'b01, 5'd9, 5'd0);
        check_eq("pending_not_active", 32'(pw_active[4:0]), 7);
        n = 0;
        prev_act0 = 32'(pw_active[4:0]);
        step();
        while (!frame_start && n < 100) begin
            prev_act0 = 32'(pw_active[4:0]);
            step();
            n++;
        end
        check_eq("active_before_fs", prev_act0, 7);
        check_eq("active_at_fs", 32'(pw_active[4:0]), 9);
        measure_frame(hi0, hi1);
        check_eq("high_ch0_9", hi0, 36);
        check_eq("high_ch1_7", hi1, 28);

        // 3: out-of-range writes
        step();
        step();
        write_pw(2'b11, 5'd2, 5'd15);
        wait_fs();
`ifdef SERVO_PWM_CLAMP_EN
        check_eq("low_write_ch0", 32'(pw_active[4:0]), 5);
        check_eq("high_write_ch1", 32'(pw_active[9:5]), 10);
`else
        check_eq("low_write_ch0", 32'(pw_active[4:0]), 2);
        check_eq("high_write_ch1", 32'(pw_active[9:5]), 15);
`endif
        measure_frame(hi0, hi1);
`ifdef SERVO_PWM_CLAMP_EN
        check_eq("high_ch0_low", hi0, 20);
        check_eq("high_ch1_high", hi1, 40);
`else
        check_eq("high_ch0_low", hi0, 8);
        check_eq("high_ch1_high", hi1, 60);
`endif
        write_pw(2'b10, 5'd0, 5'd25);
        wait_fs();
        measure_frame(hi0, hi1);
`ifdef SERVO_PWM_CLAMP_EN
        check_eq("over_period_ch1", hi1, 40);
        check_eq("over_period_ch0", hi0, 20);
`else
        check_eq("over_period_ch1", hi1, 80);
        check_eq("over_period_ch0", hi0, 8);
`endif

        // 4: write coinciding with the wrap edge takes effect in the new frame
        wait_tick_cnt(19);
        step();
        step();
        step();
        write_pw(2'b01, 5'd8, 5'd0);
        check_eq("bypass_fs", {31'd0, frame_start}, 1);
        check_eq("bypass_active", 32'(pw_active[4:0]), 8);
        measure_frame(hi0, hi1);
        check_eq("bypass_high", hi0, 32);

        // 5: disable mid-frame
        wait_tick_cnt(6);
        en = 1'b0;
        step();
        check_eq("dis_hold_cnt", 32'(tick_cnt), 6);
        check_eq("dis_pwm_low", 32'(pwm_out), 0);
        write_pw(2'b01, 5'd6, 5'd0);
        check_eq("dis_write_active", 32'(pw_active[4:0]), 6);
        strobes = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (tick || frame_start) strobes++;
        end
        check_eq("dis_no_strobes", strobes, 0);
        check_eq("dis_cnt_end", 32'(tick_cnt), 6);
        en = 1'b1;
        n  = 0;
        do begin
            step();
            n++;
        end while (!tick && n < 10);
        check_eq("resume_latency", n, 4);
        check_eq("resume_cnt", 32'(tick_cnt), 7);

        // 6: reset mid-frame
        write_pw(2'b11, 5'd9, 5'd9);
        wait_fs();
        check_eq("pre_rst_active", 32'(pw_active[4:0]), 9);
        wait_tick_cnt(12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_cnt", 32'(tick_cnt), 0);
        check_eq("mid_rst_pwm", 32'(pwm_out), 0);
        check_eq("mid_rst_active", 32'(pw_active), 32'({5'd7, 5'd7}));
        check_eq("mid_rst_fs", {31'd0, frame_start}, 0);
        strobes = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (frame_start) strobes++;
        end
        check_eq("post_rst_no_fs", strobes, 0);
        check_eq("post_rst_tick", {31'd0, tick}, 1);
        check_eq("post_rst_cnt", 32'(tick_cnt), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
